ps2_voice_allocator: RTL and testbench
======================================

// Module: ps2_voice_allocator
// PURPOSE
//   Turns the PS/2 controller's raw received-byte stream into key press/release events.
//   Decodes the make, break (F0) and extended (E0) prefixes.
//   Allocates each held key to one of NUM_VOICES synth voice slots and frees the slot on release.
//   Sits between PS2_Controller (received_data / received_data_en) and the synth voice datapath.
// PARAMETERS
//   NUM_VOICES      4          number of voice slots (1..8)
//   SLOT_W          2          width of a slot index; must satisfy 2**SLOT_W >= NUM_VOICES
//   TIMEOUT_CYCLES  1000000    idle cycles after a prefix byte before the FSM abandons the sequence (20 ms @ 50 MHz)
// PORTS
//   CLOCK_50         in   1             system clock, rising edge
//   resetn           in   1             asynchronous, active-low reset
//   ps2_key_data     in   8             received byte; valid only while ps2_key_pressed=1
//   ps2_key_pressed  in   1             1-cycle strobe, one per received byte
//   voice_active     out  NUM_VOICES    bit i = slot i holds a key
//   voice_code       out  8*NUM_VOICES  scan code of slot i in bits [8i+7:8i]
//   voice_ext        out  NUM_VOICES    bit i = slot i key was E0-prefixed
//   event_valid      out  1             1-cycle pulse: a slot was allocated or freed
//   event_release    out  1             qualifies event_valid: 0 = press, 1 = release
//   event_slot       out  SLOT_W        slot index of the event
//   overflow         out  1             1-cycle pulse: new press dropped because all slots were busy
// BEHAVIOUR
//   Reset: all outputs and the slot table are 0; FSM returns to IDLE; timeout counter is cleared.
//   All outputs are registered; reset may assert at any time, including mid-sequence.
//   FSM states: IDLE, EXT, BRK, EXT_BRK.
//   Transitions are evaluated only on cycles where ps2_key_pressed=1:
//     IDLE:    E0 -> EXT; F0 -> BRK; 00/AA/E1/FA/FC/FE/FF -> IDLE, ignored; any other byte -> PRESS(code, ext=0), -> IDLE
//     EXT:     F0 -> EXT_BRK; E0 -> EXT; any other byte -> PRESS(code, ext=1), -> IDLE
//     BRK:     E0 -> EXT; F0 -> BRK; any other byte -> RELEASE(code, ext=0), -> IDLE
//     EXT_BRK: E0 -> EXT; F0 -> BRK; any other byte -> RELEASE(code, ext=1), -> IDLE
//   Timeout:
//     - Counter is cleared on every strobe and held at 0 while in IDLE.
//     - In any other state it increments each cycle; on reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE.
//     - If a strobe and timeout expiry fall in the same cycle, the strobe wins and the byte is decoded in the current state.
//   PRESS(c, x):
//     - If an active slot already holds {c, x} (typematic repeat): no change, no event.
//     - Otherwise the lowest-index inactive slot takes {c, x}: active, code and ext are set.
//     - Then event_valid=1, event_release=0, event_slot=that slot.
//     - No free slot: table unchanged, overflow=1, event_valid=0.
//   RELEASE(c, x):
//     - The active slot matching {c, x} is cleared: active=0, code=0, ext=0.
//     - Then event_valid=1, event_release=1, event_slot=that slot.
//     - No match: ignored, no event. Matching requires both code and ext to be equal.
//   Latency:
//     - Strobe in cycle t -> table, event and overflow outputs are updated at the rising edge ending cycle t.
//     - They are visible during cycle t+1; pulses last exactly 1 cycle.
//     - event_release and event_slot hold their last value while event_valid=0.
//   Invariant: no two active slots hold the same {code, ext}. Back-to-back strobes on consecutive cycles are fully supported.
// TESTING (NUM_VOICES=4, TIMEOUT_CYCLES=100)
//   1 Reset low mid-F0 sequence -> all outputs 0, FSM IDLE; next byte 1C -> press event, slot 0.
//   2 Bytes 1C, 1C, 1C -> one press event (slot 0, voice_code[7:0]=1C); then F0 1C -> release slot 0, voice_active=0000.
//   3 E0 75 -> press slot 0, voice_ext=0001; F0 75 -> no event; E0 F0 75 -> release slot 0.
//   4 Presses 1C 1B 23 2B -> slots 0..3, voice_active=1111; 34 -> overflow pulse, no event.
//     Then F0 1B -> release slot 1; 34 -> press slot 1.
//   5 F0, wait 100 idle cycles, then 1C -> treated as press (slot 0), not release.
//     F0 followed by 1C exactly on the expiry cycle -> release.
//   6 Bytes AA, FA, FE in IDLE -> no events, table unchanged; strobes on consecutive cycles F0,1C -> release processed correctly.

Source files
------------

// File: rtl/ps2_voice_allocator.sv
// PS/2 scan-code decoder with make/break/E0 handling.
// Allocates held keys to a small table of synth voice slots.
module ps2_voice_allocator #(
  parameter int NUM_VOICES     = 4,
  parameter int SLOT_W         = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [7:0]              ps2_key_data,
  input  logic                    ps2_key_pressed,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [8*NUM_VOICES-1:0] voice_code,
  output logic [NUM_VOICES-1:0]   voice_ext,
  output logic                    event_valid,
  output logic                    event_release,
  output logic [SLOT_W-1:0]       event_slot,
  output logic                    overflow
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, EXT, BRK, EXT_BRK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_VOICES-1:0] act_q, ext_q;
  logic [7:0]         code_q [NUM_VOICES];
  logic               ev_q, rel_q, ovf_q;
  logic [SLOT_W-1:0]  slot_q;

  logic is_e0, is_f0, is_ign;
  logic press_go, rel_go, ext_go;
  logic hit, free;
  logic [SLOT_W-1:0] hit_idx, free_idx;

  assign is_e0  = (ps2_key_data == 8'hE0);
  assign is_f0  = (ps2_key_data == 8'hF0);
  assign is_ign = ps2_key_data inside
    {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  // Byte decode: next prefix state and press/release requests
  always_comb begin
    state_d  = state_q;
    press_go = 1'b0;
    rel_go   = 1'b0;
    ext_go   = 1'b0;
    if (ps2_key_pressed) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_e0:   state_d = EXT;
            is_f0:   state_d = BRK;
            is_ign:  state_d = IDLE;
            default: press_go = 1'b1;
          endcase
        end
        EXT: begin
          unique case (1'b1)
            is_f0: state_d = EXT_BRK;
            is_e0: state_d = EXT;
            default: begin
              press_go = 1'b1;
              ext_go   = 1'b1;
              state_d  = IDLE;
            end
          endcase
        end
        BRK, EXT_BRK: begin
          unique case (1'b1)
            is_e0: state_d = EXT;
            is_f0: state_d = BRK;
            default: begin
              rel_go  = 1'b1;
              ext_go  = (state_q == EXT_BRK);
              state_d = IDLE;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == LAST) begin
      state_d = IDLE;
    end
  end

  // Slot lookup: matching {code, ext} and lowest free slot
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (act_q[i] && code_q[i] == ps2_key_data &&
          ext_q[i] == ext_go) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free     = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  // Prefix FSM and idle timeout counter
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ps2_key_pressed || state_q == IDLE || cnt_q == LAST)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Voice table update and event/overflow pulses
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      act_q  <= '0;
      ext_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) code_q[i] <= 8'h00;
      ev_q   <= 1'b0;
      rel_q  <= 1'b0;
      ovf_q  <= 1'b0;
      slot_q <= '0;
    end else begin
      ev_q  <= 1'b0;
      ovf_q <= 1'b0;
      if (press_go && !hit) begin
        if (free) begin
          act_q[free_idx]  <= 1'b1;
          ext_q[free_idx]  <= ext_go;
          code_q[free_idx] <= ps2_key_data;
          ev_q   <= 1'b1;
          rel_q  <= 1'b0;
          slot_q <= free_idx;
        end else begin
          ovf_q <= 1'b1;
        end
      end
      if (rel_go && hit) begin
        act_q[hit_idx]  <= 1'b0;
        ext_q[hit_idx]  <= 1'b0;
        code_q[hit_idx] <= 8'h00;
        ev_q   <= 1'b1;
        rel_q  <= 1'b1;
        slot_q <= hit_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_code
    assign voice_code[8*g +: 8] = code_q[g];
  end

  assign voice_active  = act_q;
  assign voice_ext     = ext_q;
  assign event_valid   = ev_q;
  assign event_release = rel_q;
  assign event_slot    = slot_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Bench for ps2_voice_allocator: directed scenarios plus
// random byte streams against a timestamp-based key model.
module tb_ps2_voice_allocator;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int T  = 100;

  logic           clk = 1'b0;
  logic           rstn;
  logic [7:0]     kd;
  logic           kp;
  logic [N-1:0]   voice_active, voice_ext;
  logic [8*N-1:0] voice_code;
  logic           event_valid, event_release, overflow;
  logic [SW-1:0]  event_slot;

  ps2_voice_allocator #(
    .NUM_VOICES(N), .SLOT_W(SW), .TIMEOUT_CYCLES(T)
  ) dut (
    .CLOCK_50(clk),
    .resetn(rstn),
    .ps2_key_data(kd),
    .ps2_key_pressed(kp),
    .voice_active(voice_active),
    .voice_code(voice_code),
    .voice_ext(voice_ext),
    .event_valid(event_valid),
    .event_release(event_release),
    .event_slot(event_slot),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: key table, pending prefix with its timestamp
  bit       m_act [N];
  bit       m_ext [N];
  bit [7:0] m_code[N];
  bit       m_ev, m_rel, m_ovf;
  int       m_slot;
  bit       p_on, p_ext, p_brk;
  int       p_cyc;
  int       cyc = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_ext[i] = 0; m_code[i] = 0;
    end
    m_ev = 0; m_rel = 0; m_ovf = 0; m_slot = 0;
    p_on = 0; p_ext = 0; p_brk = 0;
  endtask

  task automatic model_press(input bit [7:0] b, input bit x);
    for (int i = 0; i < N; i++)
      if (m_act[i] && m_code[i] == b && m_ext[i] == x) return;
    for (int i = 0; i < N; i++)
      if (!m_act[i]) begin
        m_act[i] = 1; m_code[i] = b; m_ext[i] = x;
        m_ev = 1; m_rel = 0; m_slot = i;
        return;
      end
    m_ovf = 1;
  endtask

  task automatic model_release(input bit [7:0] b, input bit x);
    for (int i = 0; i < N; i++)
      if (m_act[i] && m_code[i] == b && m_ext[i] == x) begin
        m_act[i] = 0; m_code[i] = 0; m_ext[i] = 0;
        m_ev = 1; m_rel = 1; m_slot = i;
        return;
      end
  endtask

  task automatic model_step(input bit p, input bit [7:0] b);
    cyc++;
    m_ev = 0; m_ovf = 0;
    if (!p) return;
    // a prefix survives up to T cycles after its strobe
    if (p_on && (cyc - p_cyc) > T) begin
      p_on = 0; p_ext = 0; p_brk = 0;
    end
    if (b == 8'hE0) begin
      p_on = 1; p_ext = 1; p_brk = 0;
    end else if (b == 8'hF0) begin
      if (!(p_on && p_ext && !p_brk)) p_ext = 0;
      p_on = 1; p_brk = 1;
    end else if (!p_on && b inside
        {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
      // noise byte in idle
    end else begin
      if (p_brk) model_release(b, p_ext);
      else       model_press(b, p_on && p_ext);
      p_on = 0; p_ext = 0; p_brk = 0;
    end
    p_cyc = cyc;
  endtask

  task automatic check_all();
    logic [N-1:0]   a, e;
    logic [8*N-1:0] c;
    logic [SW-1:0]  s;
    for (int i = 0; i < N; i++) begin
      a[i] = m_act[i]; e[i] = m_ext[i];
      c[8*i +: 8] = m_code[i];
    end
    s = SW'(m_slot);
    chk("active", voice_active, a);
    chk("code", voice_code, c);
    chk("ext", voice_ext, e);
    chk("ev_valid", event_valid, m_ev);
    chk("ev_release", event_release, m_rel);
    chk("ev_slot", event_slot, s);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic cyc1(input bit p, input bit [7:0] b);
    @(negedge clk);
    check_all();
    kp = p; kd = b;
    model_step(p, b);
  endtask

  task automatic send(input bit [7:0] b);
    cyc1(1, b);
    cyc1(0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0; kp = 0; kd = 0;
    model_reset();
    @(negedge clk);
    check_all();
    rstn = 1;
  endtask

  bit [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hF0, 8'h1C,
                          8'h1B, 8'h23, 8'h2B, 8'h34,
                          8'h75, 8'hAA, 8'hFA, 8'h15};

  initial begin
    rstn = 0; kp = 0; kd = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rstn = 1;

    // 1: reset mid-break sequence
    cyc1(1, 8'hF0);
    cyc1(0, 8'h00);
    do_reset();
    send(8'h1C);
    chk("t1_press_s0", {event_valid, event_release, event_slot},
        {1'b1, 1'b0, 2'd0});
    send(8'hF0); send(8'h1C);

    // 2: typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("t2_code0", voice_code[7:0], 8'h1C);
    send(8'hF0); send(8'h1C);
    chk("t2_empty", voice_active, 4'b0000);

    // 3: extended keys
    send(8'hE0); send(8'h75);
    chk("t3_ext", voice_ext, 4'b0001);
    send(8'hF0); send(8'h75);
    chk("t3_noext_rel", voice_active, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t3_rel", voice_active, 4'b0000);

    // 4: fill table, overflow, reuse freed slot
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    chk("t4_full", voice_active, 4'b1111);
    send(8'h34);
    send(8'hF0); send(8'h1B);
    send(8'h34);
    chk("t4_reuse", voice_code[15:8], 8'h34);
    foreach (pool[i]) if (i >= 3 && i <= 7) begin
      send(8'hF0); send(pool[i]);
    end

    // 5: prefix timeout boundary
    send(8'h1C);
    cyc1(1, 8'hF0);
    repeat (T - 1) cyc1(0, 8'h00);
    cyc1(1, 8'h1C);
    cyc1(0, 8'h00);
    chk("t5_edge_rel", voice_active, 4'b0000);
    cyc1(1, 8'hF0);
    repeat (T) cyc1(0, 8'h00);
    cyc1(1, 8'h1C);
    cyc1(0, 8'h00);
    chk("t5_late_press", voice_active, 4'b0001);

    // 6: noise bytes, back-to-back strobes
    send(8'hAA); send(8'hFA); send(8'hFE);
    cyc1(1, 8'hF0);
    cyc1(1, 8'h1C);
    cyc1(0, 8'h00);
    chk("t6_b2b_rel", voice_active, 4'b0000);

    // random streams
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0)
        repeat ($urandom_range(T - 5, T + 5)) cyc1(0, 8'h00);
      if ($urandom_range(0, 1) == 1)
        cyc1(1, pool[$urandom_range(0, 11)]);
      else
        cyc1(0, 8'h00);
    end
    cyc1(0, 8'h00);
    cyc1(0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
